// File: rtl/ntp_axi_pkg.sv
// Shared AXI4-Lite definitions for the network-path register masters.
// Holds response codes, the command master FSM states and the counter width.
package ntp_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RSP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Ports: s_axi_clk/aresetn, cmd_* in, rsp_* out, m_axi_* AW/W/B/AR/R.
module axi_lite_cmd_master
    import ntp_axi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        s_axi_clk,
    input  logic        s_axi_aresetn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,

    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST =
        TO_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_timeout;

    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;

    logic                r_aw_pend;
    logic                r_w_pend;
    logic                r_b_pend;
    logic                r_ar_pend;
    logic                r_r_pend;

    logic [TO_CNT_W-1:0] r_cnt;

    logic w_bready;
    logic w_rready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_accept;
    logic w_any_nxt;

    // B/R are only accepted once their address/data beats are out,
    // so a response can never overtake its own request.
    assign w_bready = r_b_pend & ~r_aw_pend & ~r_w_pend;
    assign w_rready = r_r_pend & ~r_ar_pend;

    assign w_aw_hs  = r_aw_pend & m_axi_awready;
    assign w_w_hs   = r_w_pend  & m_axi_wready;
    assign w_b_hs   = w_bready  & m_axi_bvalid;
    assign w_ar_hs  = r_ar_pend & m_axi_arready;
    assign w_r_hs   = w_rready  & m_axi_rvalid;

    assign w_accept = cmd_valid & r_cmd_ready;

    // Pending state after this cycle's handshakes; lets RSP/DRAIN
    // return to IDLE on the same edge the last beat completes.
    assign w_any_nxt = (r_aw_pend & ~w_aw_hs)
                     | (r_w_pend  & ~w_w_hs)
                     | (r_b_pend  & ~w_b_hs)
                     | (r_ar_pend & ~w_ar_hs)
                     | (r_r_pend  & ~w_r_hs);

    always_ff @(posedge s_axi_clk) begin
        if (!s_axi_aresetn) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_aw_pend     <= 1'b0;
            r_w_pend      <= 1'b0;
            r_b_pend      <= 1'b0;
            r_ar_pend     <= 1'b0;
            r_r_pend      <= 1'b0;
            r_cnt         <= '0;
        end else begin
            // Flags retire on their own handshake in any state,
            // which also absorbs late responses after a timeout.
            if (w_aw_hs) r_aw_pend <= 1'b0;
            if (w_w_hs)  r_w_pend  <= 1'b0;
            if (w_b_hs)  r_b_pend  <= 1'b0;
            if (w_ar_hs) r_ar_pend <= 1'b0;
            if (w_r_hs)  r_r_pend  <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= BUSY;
                        if (cmd_we) begin
                            r_aw_pend <= 1'b1;
                            r_w_pend  <= 1'b1;
                            r_b_pend  <= 1'b1;
                        end else begin
                            r_ar_pend <= 1'b1;
                            r_r_pend  <= 1'b1;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                BUSY: begin
                    // Completion has priority over a coincident timeout.
                    if (w_b_hs || w_r_hs) begin
                        r_rsp_resp    <= w_b_hs ? m_axi_bresp : m_axi_rresp;
                        r_rsp_rdata   <= w_r_hs ? m_axi_rdata : 32'h0;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RSP;
                    end else if (TO_EN && (r_cnt == TO_LAST)) begin
                        r_rsp_resp    <= RESP_SLVERR;
                        r_rsp_rdata   <= 32'h0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RSP;
                    end else begin
                        r_cnt <= r_cnt + TO_CNT_W'(1);
                    end
                end

                RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_any_nxt) begin
                            r_state <= DRAIN;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end

                DRAIN: begin
                    if (!w_any_nxt) begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_timeout   = r_rsp_timeout;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_aw_pend;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_w_pend;
    assign m_axi_bready  = w_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_ar_pend;
    assign m_axi_rready  = w_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a response scoreboard.
// The slave side is driven step by step from the single stimulus block.
module tb_axi_lite_cmd_master;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    logic        clk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    axi_lite_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .s_axi_clk     (clk),
        .s_axi_aresetn (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command at a negedge; returns in cycle N+1.
    task automatic send_cmd(input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        chk("cmd_ready_pre", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] r,
                            input logic t);
        exp_t e;
        e.rdata = d;
        e.resp  = r;
        e.to    = t;
        sb.push_back(e);
    endtask

    // Wait (bounded) for rsp_valid, compare against the scoreboard,
    // then handshake; returns in cycle P+1.
    task automatic get_rsp(input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (!rsp_valid && n < budget) begin
            tick();
            n++;
        end
        chk("rsp_valid_wait", 32'(rsp_valid), 32'h1);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
        if (rsp_valid && sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] hold;
        n_chk     = 0;
        n_fail    = 0;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'b00;
        bvalid    = 1'b0;
        arready   = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rvalid    = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready,
                           rsp_valid, rsp_timeout}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        aresetn = 1'b1;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'h1);

        // Best-case write
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        bresp   = 2'b00;
        push_exp(32'h0, 2'b00, 1'b0);
        send_cmd(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF);
        chk("w1_aw_w_valid", {awvalid, wvalid}, 32'h3);
        chk("w1_awaddr", awaddr, 32'h0000_0010);
        chk("w1_wdata", wdata, 32'hCAFE_F00D);
        chk("w1_wstrb", 32'(wstrb), 32'hF);
        chk("w1_prot", {awprot, arprot}, 32'h0);
        chk("w1_cmd_ready", 32'(cmd_ready), 32'h0);
        tick();
        chk("w1_n2", {awvalid, wvalid, bready}, 32'h1);
        tick();
        chk("w1_n3_rsp_valid", 32'(rsp_valid), 32'h1);
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        get_rsp(4);
        chk("w1_cmd_ready_post", 32'(cmd_ready), 32'h1);

        // Read with 5 wait cycles on arready
        push_exp(32'hDEAD_BEEF, 2'b00, 1'b0);
        send_cmd(1'b0, 32'h0000_0024, 32'h0, 4'h0);
        chk("r1_araddr", araddr, 32'h0000_0024);
        for (int i = 0; i < 5; i++) begin
            chk("r1_arvalid_hold", {arvalid, rready}, 32'h2);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r1_ar_done", {arvalid, rready}, 32'h1);
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        rresp  = 2'b00;
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        chk("r1_rsp_valid", 32'(rsp_valid), 32'h1);
        get_rsp(4);

        // Skewed write: AW at N+1, W at N+4, early bvalid ignored
        push_exp(32'h0, 2'b10, 1'b0);
        send_cmd(1'b1, 32'h0000_0040, 32'h0BAD_0001, 4'h3);
        awready = 1'b1;
        bvalid  = 1'b1;
        bresp   = 2'b10;
        chk("sk_n1", {awvalid, wvalid, bready}, 32'h6);
        tick();
        awready = 1'b0;
        chk("sk_n2", {awvalid, wvalid, bready}, 32'h2);
        tick();
        chk("sk_n3", {awvalid, wvalid, bready, rsp_valid}, 32'h4);
        tick();
        wready = 1'b1;
        chk("sk_n4", {awvalid, wvalid, bready}, 32'h2);
        tick();
        wready = 1'b0;
        chk("sk_n5", {awvalid, wvalid, bready, rsp_valid}, 32'h2);
        tick();
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk("sk_n6_rsp_valid", 32'(rsp_valid), 32'h1);
        get_rsp(4);

        // Timeout on a read whose arready never comes
        push_exp(32'h0, 2'b10, 1'b1);
        send_cmd(1'b0, 32'h0000_0080, 32'h0, 4'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("to_n16", {arvalid, rsp_valid}, 32'h2);
        tick();
        chk("to_n17", {arvalid, rsp_valid}, 32'h3);
        get_rsp(2);
        chk("to_drain", {arvalid, rsp_valid, cmd_ready}, 32'h4);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("to_ar_done", {arvalid, rready, cmd_ready}, 32'h2);
        rvalid = 1'b1;
        rdata  = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        chk("to_idle", {cmd_ready, rsp_valid, rready}, 32'h4);
        chk("to_sb_empty", 32'(sb.size()), 32'h0);

        // Completed read held by rsp_ready low for 10 cycles
        push_exp(32'hA5A5_0F0F, 2'b01, 1'b0);
        send_cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hA5A5_0F0F;
        rresp   = 2'b01;
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        rresp  = 2'b00;
        hold   = 32'hA5A5_0F0F;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid_cr", {rsp_valid, cmd_ready}, 32'h2);
            chk("hold_rdata", rsp_rdata, hold);
            tick();
        end
        get_rsp(2);
        chk("hold_cmd_ready_post", 32'(cmd_ready), 32'h1);

        // Reset mid-transaction, then a normal read
        send_cmd(1'b1, 32'h0000_0050, 32'h5555_AAAA, 4'hF);
        chk("mr_awvalid", 32'(awvalid), 32'h1);
        aresetn = 1'b0;
        tick();
        chk("mr_outs", {awvalid, wvalid, bready, arvalid, rready,
                        rsp_valid, cmd_ready}, 32'h0);
        chk("mr_awaddr", awaddr, 32'h0);
        aresetn = 1'b1;
        tick();
        chk("mr_cmd_ready", 32'(cmd_ready), 32'h1);
        push_exp(32'h600D_F00D, 2'b00, 1'b0);
        send_cmd(1'b0, 32'h0000_0060, 32'h0, 4'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h600D_F00D;
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        get_rsp(4);
        chk("mr_final_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite master that turns simple command/response handshakes into AXI4-Lite write and read transactions. It drives the slave register ports of the network path and key memory blocks, for self-test benches, in-fabric configuration sequencers and loopback register checks. It has a per-transaction timeout that reports a hung slave without violating AXI handshake rules.

## Interface
- TIMEOUT_CYCLES, 1024: cycles from the first bus-valid cycle to timeout; 0 disables the timeout; maximum 65535.
- s_axi_clk  in  1  sole clock.
- s_axi_aresetn  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout.
- rsp_timeout  out  1  transaction timed out.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  write address channel; awprot = 3'b000.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  read address channel; arprot = 3'b000.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel.

## Operation
- FSM states: IDLE, BUSY, RSP, DRAIN.
- cmd_ready = (state == IDLE).
- Command accept (cmd_valid & cmd_ready):
  - Latch addr, wdata and wstrb.
  - Write: set pending flags aw_pend, w_pend, b_pend. Read: set ar_pend, r_pend.
  - Clear the timeout counter and go to BUSY.
- Bus outputs come only from the pending flags, not from FSM state:
  - awvalid = aw_pend, wvalid = w_pend, arvalid = ar_pend.
  - bready = b_pend & !aw_pend & !w_pend.
  - rready = r_pend & !ar_pend.
- Each flag clears on its own channel handshake (valid & ready).
- AW and W are independent: either may complete first or both in the same cycle.
- Once a valid is raised it stays high until its handshake, including after timeout. No AXI rule is ever broken.
- BUSY:
  - On B or R handshake, register resp (and rdata for reads), set rsp_timeout = 0, go to RSP.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES != 0), load resp = 2'b10, rdata = 0, rsp_timeout = 1, go to RSP.
  - If completion and timeout fall in the same cycle, completion wins.
- RSP:
  - rsp_valid = 1; outputs stay stable until rsp_ready.
  - On rsp_ready, go to DRAIN if any pending flag is still set, else to IDLE.
- DRAIN: wait until all pending flags clear, then go to IDLE.
- A B or R that arrives late (in RSP or DRAIN) is accepted on the bus and its data discarded.

## Timing
- Reset values: every output 0 (cmd_ready 0 during reset, 1 the first cycle after release); all flags 0; state IDLE.
- Accept at cycle N: awvalid/wvalid or arvalid high at N+1. The counter is 0 at N+1, so a timeout response appears at N+1+TIMEOUT_CYCLES.
- Channel handshake at cycle K: that valid is low at K+1.
- AW and W both done at K: bready high at K+1.
- B/R handshake at M: rsp_valid high at M+1.
- Best case, a slave with ready always high:
  - write: bready at N+2, rsp_valid at N+3 if bvalid is high at N+2.
  - read: rsp_valid at N+3.
- After the rsp handshake at P with nothing pending: cmd_ready high at P+1.
- Reset asserted mid-transaction: all flags, valids, readys and rsp_valid go to 0 on the next edge. The slave must be reset in the same domain.

## Structure
- Shared package ntp_axi_pkg holds:
  - AXI resp constants: RESP_OKAY 2'b00, RESP_SLVERR 2'b10.
  - The FSM state enum (IDLE, BUSY, RSP, DRAIN).
  - A 16-bit timeout counter width constant.
- No sub-module: one flat module with an FSM, five pending flags, latched command, response registers and a counter.

## Test plan
- Write 0x0000_0010 ← 0xCAFE_F00D, wstrb 4'hF, slave with all readys high and bresp 2'b00 → awvalid/wvalid at N+1, rsp_valid at N+3, rsp_resp 2'b00, rsp_rdata 0, rsp_timeout 0.
- Read 0x0000_0024, slave returns rdata 0xDEAD_BEEF and rresp 2'b00 after 5 wait cycles → rsp_rdata 0xDEAD_BEEF, rsp_resp 2'b00; arvalid held until arready.
- Skewed write: awready at N+1, wready at N+4 → awvalid low at N+2, wvalid low at N+5, bready first high at N+5; any bvalid earlier is not accepted.
- TIMEOUT_CYCLES=16, slave never raises arready:
  - rsp_valid at N+17 with rsp_resp 2'b10, rsp_timeout 1, rsp_rdata 0.
  - arvalid stays high; the FSM moves to DRAIN.
  - Slave then completes with rdata 0x1234_5678 → data discarded; cmd_ready returns the cycle after the R handshake.
- rsp_ready held low for 10 cycles with a completed read → rsp_valid and rsp_rdata stable throughout; cmd_ready low until the cycle after the rsp handshake.
- s_axi_aresetn pulled low for one cycle while awvalid is high → all outputs 0 the next cycle; cmd_ready 1 the cycle after release; a new read then completes normally.
